// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART definitions: FSM state encoding, default bit timing and data mask
// Contents:
//   uart_state_e        receiver/transmitter FSM state encoding
//   UART_CLKS_PER_BIT   default clk cycles per bit (100 MHz / 9600 baud)
//   UART_DATA_XOR_MASK  default mask undoing the bit-5 inversion on the wire
//   uart_maj3           2-of-3 majority helper
package uart_pkg;

    localparam int unsigned UART_CLKS_PER_BIT  = 10416;
    localparam logic [7:0]  UART_DATA_XOR_MASK = 8'h20;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    function automatic logic uart_maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop synchroniser for the serial line plus falling-edge detect
// Ports:
//   clk_i  in   system clock
//   rst_i  in   synchronous active-high reset; all flops load 1 (idle line)
//   rxd    in   asynchronous serial line
//   rxs    out  synchronised line
//   fall   out  rxs went 1 -> 0 on the last clock edge
module uart_rx_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic rxd,
    output logic rxs,
    output logic fall
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= rxd;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rxs  = sync_q;
    assign fall = prev_q & ~sync_q;

endmodule

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 8N1 UART receiver with mid-bit sampling, data-bit-5 unmask and hold register
// Optional build macro: RX_MAJORITY_VOTE_EN (2-of-3 vote per sample point, decision one cycle later)
// Ports:
//   clk_i        in   system clock
//   rst_i        in   synchronous active-high reset
//   RXD_i        in   asynchronous serial line, idle high
//   data_o       out  received byte, valid while rdy_o=1
//   rdy_o        out  byte available, held until rd_i
//   rd_i         in   consumer read strobe, clears rdy_o and overrun_o
//   overrun_o    out  sticky: a frame completed while rdy_o=1
//   frame_err_o  out  one-cycle pulse: stop bit sampled low
//   busy_o       out  high whenever the FSM is not idle
module uart_receiver
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT  = UART_CLKS_PER_BIT,
    parameter logic [7:0]  DATA_XOR_MASK = UART_DATA_XOR_MASK
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       RXD_i,
    output logic [7:0] data_o,
    output logic       rdy_o,
    input  logic       rd_i,
    output logic       overrun_o,
    output logic       frame_err_o,
    output logic       busy_o
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic rxs;
    logic fall;
    logic sample;

    uart_rx_sync u_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .rxd   (RXD_i),
        .rxs   (rxs),
        .fall  (fall)
    );

`ifdef RX_MAJORITY_VOTE_EN
    // The start decision is one cycle late, so DATA/STOP are entered one cycle late as well;
    // their decision at CNT_LAST therefore already sits one cycle after the nominal centre.
    localparam logic [CNT_W-1:0] CNT_START = CNT_W'(CLKS_PER_BIT / 2);
    logic [1:0] hist_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hist_q <= 2'b11;
        end else begin
            hist_q <= {hist_q[0], rxs};
        end
    end

    assign sample = uart_maj3(hist_q[1], hist_q[0], rxs);
`else
    localparam logic [CNT_W-1:0] CNT_START = CNT_W'(CLKS_PER_BIT / 2 - 1);

    assign sample = rxs;
`endif

    uart_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bit_idx_q;
    logic [7:0]       shift_q;
    logic             data_tick;
    logic             good_frame;
    logic             stop_err;

    always_comb begin
        state_d    = state_q;
        data_tick  = 1'b0;
        good_frame = 1'b0;
        stop_err   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // fall only fires on a 1->0 edge, so a held-low break cannot restart a frame
                if (fall) state_d = ST_START;
            end
            ST_START: begin
                if (cnt_q == CNT_START) state_d = sample ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    data_tick = 1'b1;
                    if (bit_idx_q == 3'd7) state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                // leave mid-stop-bit so a back-to-back start edge is not missed
                if (cnt_q == CNT_LAST) begin
                    state_d    = ST_IDLE;
                    good_frame = sample;
                    stop_err   = ~sample;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            if (state_d != state_q || cnt_q == CNT_LAST) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (state_d == ST_DATA && state_q != ST_DATA) begin
                bit_idx_q <= 3'd0;
            end else if (data_tick) begin
                shift_q[bit_idx_q] <= sample;
                bit_idx_q          <= bit_idx_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_o      <= 8'h00;
            rdy_o       <= 1'b0;
            overrun_o   <= 1'b0;
            frame_err_o <= 1'b0;
        end else begin
            frame_err_o <= stop_err;
            if (good_frame) begin
                if (!rdy_o || rd_i) begin
                    data_o <= shift_q ^ DATA_XOR_MASK;
                    rdy_o  <= 1'b1;
                end else begin
                    overrun_o <= 1'b1;
                end
            end else if (rd_i && rdy_o) begin
                rdy_o     <= 1'b0;
                overrun_o <= 1'b0;
            end
        end
    end

    assign busy_o = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - directed self-checking bench for uart_receiver with a byte scoreboard
module tb_uart_receiver;

    localparam int N = 16;

    logic       clk = 1'b0;
    logic       rst_i;
    logic       RXD_i;
    logic       rd_i;
    logic [7:0] data_o;
    logic       rdy_o;
    logic       overrun_o;
    logic       frame_err_o;
    logic       busy_o;

    uart_receiver #(.CLKS_PER_BIT(N), .DATA_XOR_MASK(8'h20)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .RXD_i       (RXD_i),
        .data_o      (data_o),
        .rdy_o       (rdy_o),
        .rd_i        (rd_i),
        .overrun_o   (overrun_o),
        .frame_err_o (frame_err_o),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   rdy_rises = 0;
    int   t_rdy = 0;
    int   fe_cycles = 0;
    logic rdy_prev = 1'b0;

    logic [7:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rdy_o && !rdy_prev) begin
            t_rdy = cyc;
            rdy_rises++;
        end
        rdy_prev = rdy_o;
        if (frame_err_o) fe_cycles++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_pop(input string tag);
        logic [7:0] e;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $error("FAIL %s: observed %0h, expected <empty scoreboard>", tag, data_o);
        end else begin
            e = exp_q.pop_front();
            check(tag, {24'h0, data_o}, {24'h0, e});
        end
    endtask

    // Drives start, 8 data bits LSB first and the stop bit; the line is left at the stop level.
    // rd_i is pulsed at negedge number rd_off counted from the start-bit edge (-1: never).
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int rd_off,
                              output int t0);
        logic [2:0] bi;
        t0 = 0;
        for (int c = 0; c < 10 * N; c++) begin
            @(negedge clk);
            if (c == 0) t0 = cyc;
            bi = 3'((c / N) - 1);
            if (c < N)          RXD_i = 1'b0;
            else if (c < 9 * N) RXD_i = b[bi];
            else                RXD_i = stop_bit;
            rd_i = (c == rd_off);
        end
        @(negedge clk);
        rd_i = 1'b0;
    endtask

    task automatic idle_bits(input int k);
        repeat (k * N) @(negedge clk);
    endtask

    task automatic do_read();
        @(negedge clk);
        rd_i = 1'b1;
        @(negedge clk);
        rd_i = 1'b0;
    endtask

    initial begin
        int t_fall;
        int lat;
        int base_r;
        int base_fe;
        logic [7:0] b5;
        logic [2:0] bi;

        rst_i = 1'b1;
        RXD_i = 1'b1;
        rd_i  = 1'b0;
        lat   = 155;
        repeat (3) @(negedge clk);
        check("reset_data", {24'h0, data_o}, 32'h0);
        check("reset_rdy", {31'h0, rdy_o}, 32'h0);
        check("reset_overrun", {31'h0, overrun_o}, 32'h0);
        check("reset_frame_err", {31'h0, frame_err_o}, 32'h0);
        check("reset_busy", {31'h0, busy_o}, 32'h0);
        rst_i = 1'b0;
        idle_bits(1);

        // 1: single good frame and latency window
        base_r  = rdy_rises;
        base_fe = fe_cycles;
        exp_q.push_back(8'h75);
        send_frame(8'h55, 1'b1, -1, t_fall);
        RXD_i = 1'b1;
        check("t1_rdy", {31'h0, rdy_o}, 32'h1);
        check("t1_rises", rdy_rises, base_r + 1);
        lat = t_rdy - t_fall;
        check("t1_latency_in_window", {31'h0, (lat >= 152 && lat <= 157)}, 32'h1);
        check_pop("t1_data");
        check("t1_frame_err", fe_cycles, base_fe);
        check("t1_overrun", {31'h0, overrun_o}, 32'h0);
        do_read();
        check("t1_rdy_cleared", {31'h0, rdy_o}, 32'h0);

        // 2: back-to-back frames without reading -> overrun, first byte kept
        exp_q.push_back(8'h20);
        send_frame(8'h00, 1'b1, -1, t_fall);
        check_pop("t2_first_data");
        check("t2_first_overrun", {31'h0, overrun_o}, 32'h0);
        send_frame(8'hFF, 1'b1, -1, t_fall);
        check("t2_overrun", {31'h0, overrun_o}, 32'h1);
        check("t2_data_kept", {24'h0, data_o}, 32'h20);
        check("t2_rdy", {31'h0, rdy_o}, 32'h1);
        do_read();
        check("t2_rdy_cleared", {31'h0, rdy_o}, 32'h0);
        check("t2_overrun_cleared", {31'h0, overrun_o}, 32'h0);

        // 3: quarter-bit glitch on idle line
        base_r  = rdy_rises;
        base_fe = fe_cycles;
        @(negedge clk);
        RXD_i = 1'b0;
        repeat (N / 4) @(negedge clk);
        check("t3_busy_on_glitch", {31'h0, busy_o}, 32'h1);
        RXD_i = 1'b1;
        idle_bits(2);
        check("t3_busy_back", {31'h0, busy_o}, 32'h0);
        check("t3_rdy", {31'h0, rdy_o}, 32'h0);
        check("t3_frame_err", fe_cycles, base_fe);
        check("t3_rises", rdy_rises, base_r);

        // 4: stop bit low, line held low for three bit times
        base_r  = rdy_rises;
        base_fe = fe_cycles;
        send_frame(8'hA5, 1'b0, -1, t_fall);
        repeat (2 * N) @(negedge clk);
        RXD_i = 1'b1;
        idle_bits(2);
        check("t4_frame_err_pulse", fe_cycles, base_fe + 1);
        check("t4_rdy", {31'h0, rdy_o}, 32'h0);
        check("t4_rises", rdy_rises, base_r);
        check("t4_busy", {31'h0, busy_o}, 32'h0);

        // 5: reset in the middle of data bit 4, then a clean frame
        b5 = 8'h3C;
        for (int c = 0; c < 5 * N + N / 2; c++) begin
            @(negedge clk);
            bi = 3'((c / N) - 1);
            RXD_i = (c < N) ? 1'b0 : b5[bi];
        end
        check("t5_busy_before_reset", {31'h0, busy_o}, 32'h1);
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        RXD_i = 1'b1;
        check("t5_reset_data", {24'h0, data_o}, 32'h0);
        check("t5_reset_rdy", {31'h0, rdy_o}, 32'h0);
        check("t5_reset_overrun", {31'h0, overrun_o}, 32'h0);
        check("t5_reset_frame_err", {31'h0, frame_err_o}, 32'h0);
        check("t5_reset_busy", {31'h0, busy_o}, 32'h0);
        base_r = rdy_rises;
        idle_bits(12);
        check("t5_no_output_after_abort", rdy_rises, base_r);
        exp_q.push_back(8'h1C);
        send_frame(8'h3C, 1'b1, -1, t_fall);
        check("t5_rdy", {31'h0, rdy_o}, 32'h1);
        check_pop("t5_data");

        // 6: read strobe on the very cycle a second good frame completes
        exp_q.push_back(8'h2F);
        send_frame(8'h0F, 1'b1, lat - 1, t_fall);
        check("t6_rdy", {31'h0, rdy_o}, 32'h1);
        check_pop("t6_data");
        check("t6_overrun", {31'h0, overrun_o}, 32'h0);
        check("t6_scoreboard_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
